// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, issues word-aligned fetches, buffers responses for decode.
// Optional FETCH_MISALIGN_EN adds a misalign pulse output and a HALT state for misaligned redirects.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
`ifdef FETCH_MISALIGN_EN
    ,
    output logic        misalign
`endif
);

    localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUF_DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_FLUSH = 2'd2
`ifdef FETCH_MISALIGN_EN
        ,
        S_HALT  = 2'd3
`endif
    } state_t;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   drop, drop_nxt;
    logic [CNT_W-1:0]   outstanding, out_nxt;
    logic [CNT_W-1:0]   occ;
    logic [31:0]        pc;
    logic [31:0]        redirect_pc_al;

    logic [31:0]        buf_data [BUF_DEPTH];
    logic [31:0]        buf_pc   [BUF_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;

    // PC of every in-flight request, popped by every response (kept or dropped)
    logic [31:0]        pcq [BUF_DEPTH];
    logic [PTR_W-1:0]   pcq_wr, pcq_rd;

    logic credit_ok, redir, redir_ok, req_fire, rsp_fire, push, pop;

    assign credit_ok      = (SUM_W'(occ) + SUM_W'(outstanding)) < SUM_W'(BUF_DEPTH);
    assign redir          = redirect && (state != S_IDLE);
    assign redirect_pc_al = redirect_pc & ~32'h0000_0003;

`ifdef FETCH_MISALIGN_EN
    logic redir_bad;
    assign redir_bad = redir && (redirect_pc[1:0] != 2'b00);
    assign redir_ok  = redir && !redir_bad;
`else
    assign redir_ok  = redir;
`endif

    assign imem_req_valid = (state == S_FETCH) && credit_ok && !redirect;
    assign imem_addr      = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign rsp_fire       = imem_rsp_valid && (outstanding != '0);
    assign push           = rsp_fire && (state == S_FETCH) && !redir;
    assign inst_valid     = (occ != '0);
    assign pop            = inst_valid && inst_ready;
    assign inst           = buf_data[rd_ptr];
    assign inst_pc        = buf_pc[rd_ptr];
    assign out_nxt        = outstanding + CNT_W'(req_fire) - CNT_W'(rsp_fire);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            drop  <= '0;
        end else begin
            state <= state_nxt;
            drop  <= drop_nxt;
        end
    end

    // drop tracks stale responses; it is re-armed from the post-response outstanding count
    always_comb begin
        state_nxt = state;
        drop_nxt  = drop;
        case (state)
            S_IDLE:  state_nxt = S_FETCH;
            S_FLUSH: begin
                if (rsp_fire) drop_nxt = drop - CNT_W'(1);
                if (drop_nxt == '0) state_nxt = S_FETCH;
            end
            default: ;
        endcase
        if (redir_ok) begin
            drop_nxt  = out_nxt;
            state_nxt = (out_nxt != '0) ? S_FLUSH : S_FETCH;
        end
`ifdef FETCH_MISALIGN_EN
        if (redir_bad) begin
            drop_nxt  = '0;
            state_nxt = S_HALT;
        end
`endif
    end

`ifdef FETCH_MISALIGN_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) misalign <= 1'b0;
        else          misalign <= redir_bad;
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc          <= RESET_PC;
            outstanding <= '0;
            occ         <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            pcq_wr      <= '0;
            pcq_rd      <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_data[i] <= '0;
                buf_pc[i]   <= '0;
                pcq[i]      <= '0;
            end
        end else begin
            outstanding <= out_nxt;
            if (redir_ok)      pc <= redirect_pc_al;
            else if (req_fire) pc <= pc + 32'd4;

            if (req_fire) begin
                pcq[pcq_wr] <= pc;
                pcq_wr      <= ptr_inc(pcq_wr);
            end
            if (rsp_fire) pcq_rd <= ptr_inc(pcq_rd);

            if (redir) begin
                occ    <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) begin
                    buf_data[wr_ptr] <= imem_rsp_data;
                    buf_pc[wr_ptr]   <= pcq[pcq_rd];
                    wr_ptr           <= ptr_inc(wr_ptr);
                end
                if (pop) rd_ptr <= ptr_inc(rd_ptr);
                occ <= occ + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: in-order memory model with settable latency, plus a
// second instance with RESET_PC near the top of the address space for the wrap case.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = 32'h0;
    logic        inst_valid, inst_ready;
    logic [31:0] inst, inst_pc;
    logic        redirect;
    logic [31:0] redirect_pc;

    logic        hi_req_valid, hi_inst_valid;
    logic [31:0] hi_addr, hi_inst, hi_inst_pc;
    logic        hi_rsp_valid = 1'b0;
    logic [31:0] hi_rsp_data  = 32'h0;
`ifdef FETCH_MISALIGN_EN
    logic        misalign, hi_misalign;
`endif

    int          pass_cnt = 0;
    int          total_cnt = 0;
    int          lat = 1;
    logic        ovf = 1'b0;
    logic [31:0] reqs[$], ipcs[$], idat[$], hreqs[$], hpcs[$];

    fetch_sequencer #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
        .clk(clk), .reset_n(reset_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
        .redirect(redirect), .redirect_pc(redirect_pc)
`ifdef FETCH_MISALIGN_EN
        , .misalign(misalign)
`endif
    );

    fetch_sequencer #(.RESET_PC(32'hFFFF_FFF8), .BUF_DEPTH(2)) dut_hi (
        .clk(clk), .reset_n(reset_n),
        .imem_req_valid(hi_req_valid), .imem_req_ready(1'b1), .imem_addr(hi_addr),
        .imem_rsp_valid(hi_rsp_valid), .imem_rsp_data(hi_rsp_data),
        .inst_valid(hi_inst_valid), .inst_ready(1'b1), .inst(hi_inst), .inst_pc(hi_inst_pc),
        .redirect(1'b0), .redirect_pc(32'h0)
`ifdef FETCH_MISALIGN_EN
        , .misalign(hi_misalign)
`endif
    );

    always #5 clk = ~clk;

    // In-order memory: a request accepted on edge e is answered on edge e+lat with ~addr
    typedef struct { logic [31:0] addr; int due; } mreq_t;
    mreq_t mq[$];
    int    cyc = 0;
    always @(posedge clk) begin
        if (reset_n !== 1'b1) begin
            mq.delete();
            cyc = 0;
        end else begin
            if (imem_rsp_valid) void'(mq.pop_front());
            if (imem_req_valid && imem_req_ready) mq.push_back('{imem_addr, cyc + lat});
            cyc++;
        end
        #1;
        if (reset_n === 1'b1 && mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = ~mq[0].addr;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
    end

    logic        hacc;
    logic [31:0] haddr;
    always @(posedge clk) begin
        hacc  = hi_req_valid && (reset_n === 1'b1);
        haddr = hi_addr;
        #1;
        hi_rsp_valid = hacc && (reset_n === 1'b1);
        hi_rsp_data  = ~haddr;
    end

    always @(negedge clk) begin
        if (reset_n === 1'b1 && int'(dut.occ) > 2) ovf = 1'b1;
    end

    function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
    endfunction

    // Inputs are already set for the coming edge; log the handshakes that edge will perform
    task automatic tick();
        #1;
        if (imem_req_valid && imem_req_ready) reqs.push_back(imem_addr);
        if (inst_valid && inst_ready) begin
            ipcs.push_back(inst_pc);
            idat.push_back(inst);
        end
        if (hi_req_valid) hreqs.push_back(hi_addr);
        if (hi_inst_valid) hpcs.push_back(hi_inst_pc);
        @(negedge clk);
    endtask

    task automatic do_reset(input int l, input logic ir);
        reset_n        = 1'b0;
        redirect       = 1'b0;
        redirect_pc    = 32'h0;
        imem_req_ready = 1'b1;
        inst_ready     = ir;
        lat            = l;
        repeat (2) @(negedge clk);
        reqs.delete(); ipcs.delete(); idat.delete(); hreqs.delete(); hpcs.delete();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        imem_req_ready = 1'b1; inst_ready = 1'b1; lat = 1;
        repeat (2) @(negedge clk);
        total_cnt++; if (imem_req_valid !== 1'b0) $display("FAIL reset_req_valid got %0b want 0", imem_req_valid); else pass_cnt++;
        total_cnt++; if (imem_addr !== 32'h0) $display("FAIL reset_addr got %h want 00000000", imem_addr); else pass_cnt++;
        total_cnt++; if (inst_valid !== 1'b0) $display("FAIL reset_inst_valid got %0b want 0", inst_valid); else pass_cnt++;
        total_cnt++; if (inst !== 32'h0) $display("FAIL reset_inst got %h want 00000000", inst); else pass_cnt++;
        total_cnt++; if (inst_pc !== 32'h0) $display("FAIL reset_inst_pc got %h want 00000000", inst_pc); else pass_cnt++;
        total_cnt++; if (hi_addr !== 32'hFFFF_FFF8) $display("FAIL reset_hi_addr got %h want fffffff8", hi_addr); else pass_cnt++;
        reset_n = 1'b1;
        #1;
        total_cnt++; if (imem_req_valid !== 1'b0) $display("FAIL idle_req_valid got %0b want 0", imem_req_valid); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (imem_req_valid !== 1'b1) $display("FAIL first_req_valid got %0b want 1", imem_req_valid); else pass_cnt++;
        total_cnt++; if (imem_addr !== 32'h0) $display("FAIL first_req_addr got %h want 00000000", imem_addr); else pass_cnt++;
    endtask

    task automatic test_stream();
        do_reset(1, 1'b1);
        repeat (20) tick();
        total_cnt++; if (qget(reqs, 0) !== 32'h0) $display("FAIL stream_req0 got %h want 00000000", qget(reqs, 0)); else pass_cnt++;
        total_cnt++; if (qget(reqs, 1) !== 32'h4) $display("FAIL stream_req1 got %h want 00000004", qget(reqs, 1)); else pass_cnt++;
        total_cnt++; if (qget(reqs, 2) !== 32'h8) $display("FAIL stream_req2 got %h want 00000008", qget(reqs, 2)); else pass_cnt++;
        total_cnt++; if (qget(reqs, 3) !== 32'hC) $display("FAIL stream_req3 got %h want 0000000c", qget(reqs, 3)); else pass_cnt++;
        total_cnt++; if (qget(ipcs, 0) !== 32'h0) $display("FAIL stream_pc0 got %h want 00000000", qget(ipcs, 0)); else pass_cnt++;
        total_cnt++; if (qget(ipcs, 1) !== 32'h4) $display("FAIL stream_pc1 got %h want 00000004", qget(ipcs, 1)); else pass_cnt++;
        total_cnt++; if (qget(ipcs, 2) !== 32'h8) $display("FAIL stream_pc2 got %h want 00000008", qget(ipcs, 2)); else pass_cnt++;
        total_cnt++; if (qget(idat, 0) !== 32'hFFFF_FFFF) $display("FAIL stream_dat0 got %h want ffffffff", qget(idat, 0)); else pass_cnt++;
        total_cnt++; if (qget(idat, 1) !== 32'hFFFF_FFFB) $display("FAIL stream_dat1 got %h want fffffffb", qget(idat, 1)); else pass_cnt++;
        total_cnt++; if (qget(idat, 2) !== 32'hFFFF_FFF7) $display("FAIL stream_dat2 got %h want fffffff7", qget(idat, 2)); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        int n;
        do_reset(1, 1'b0);
        repeat (10) tick();
        total_cnt++; if (reqs.size() != 2) $display("FAIL bp_req_count got %0d want 2", reqs.size()); else pass_cnt++;
        total_cnt++; if (qget(reqs, 1) !== 32'h4) $display("FAIL bp_req1 got %h want 00000004", qget(reqs, 1)); else pass_cnt++;
        total_cnt++; if (imem_req_valid !== 1'b0) $display("FAIL bp_req_valid got %0b want 0", imem_req_valid); else pass_cnt++;
        total_cnt++; if (inst_valid !== 1'b1) $display("FAIL bp_inst_valid got %0b want 1", inst_valid); else pass_cnt++;
        total_cnt++; if (inst_pc !== 32'h0) $display("FAIL bp_inst_pc got %h want 00000000", inst_pc); else pass_cnt++;
        total_cnt++; if (inst !== 32'hFFFF_FFFF) $display("FAIL bp_inst got %h want ffffffff", inst); else pass_cnt++;
        inst_ready = 1'b1;
        n = 0;
        while (reqs.size() < 3 && n < 20) begin tick(); n++; end
        total_cnt++; if (qget(reqs, 2) !== 32'h8) $display("FAIL bp_resume_req got %h want 00000008", qget(reqs, 2)); else pass_cnt++;
    endtask

    task automatic test_redirect_flush();
        int n;
        do_reset(4, 1'b1);
        n = 0;
        while (reqs.size() < 2 && n < 20) begin tick(); n++; end
        total_cnt++; if (reqs.size() != 2) $display("FAIL rd_inflight got %0d want 2", reqs.size()); else pass_cnt++;
        redirect = 1'b1;
        redirect_pc = 32'h0040_0010;
        #1;
        total_cnt++; if (imem_req_valid !== 1'b0) $display("FAIL rd_req_forced got %0b want 0", imem_req_valid); else pass_cnt++;
        tick();
        redirect = 1'b0;
        total_cnt++; if (dut.state !== 2'd2) $display("FAIL rd_flush_state got %0d want 2", dut.state); else pass_cnt++;
        total_cnt++; if (imem_addr !== 32'h0040_0010) $display("FAIL rd_pc got %h want 00400010", imem_addr); else pass_cnt++;
        n = 0;
        while (!imem_req_valid && n < 20) begin tick(); n++; end
        total_cnt++; if (n != 3) $display("FAIL rd_flush_cycles got %0d want 3", n); else pass_cnt++;
        total_cnt++; if (ipcs.size() != 0) $display("FAIL rd_stale_delivered got %0d want 0", ipcs.size()); else pass_cnt++;
        n = 0;
        while (ipcs.size() == 0 && n < 20) begin tick(); n++; end
        total_cnt++; if (qget(ipcs, 0) !== 32'h0040_0010) $display("FAIL rd_first_pc got %h want 00400010", qget(ipcs, 0)); else pass_cnt++;
        total_cnt++; if (qget(idat, 0) !== 32'hFFBF_FFEF) $display("FAIL rd_first_dat got %h want ffbfffef", qget(idat, 0)); else pass_cnt++;
    endtask

    task automatic test_wrap();
        do_reset(1, 1'b1);
        repeat (16) tick();
        total_cnt++; if (qget(hreqs, 0) !== 32'hFFFF_FFF8) $display("FAIL wrap_req0 got %h want fffffff8", qget(hreqs, 0)); else pass_cnt++;
        total_cnt++; if (qget(hreqs, 1) !== 32'hFFFF_FFFC) $display("FAIL wrap_req1 got %h want fffffffc", qget(hreqs, 1)); else pass_cnt++;
        total_cnt++; if (qget(hreqs, 2) !== 32'h0) $display("FAIL wrap_req2 got %h want 00000000", qget(hreqs, 2)); else pass_cnt++;
        total_cnt++; if (qget(hpcs, 2) !== 32'h0) $display("FAIL wrap_pc2 got %h want 00000000", qget(hpcs, 2)); else pass_cnt++;
    endtask

    task automatic test_misalign();
        int n, nr, ni;
        do_reset(1, 1'b1);
        repeat (6) tick();
        redirect = 1'b1;
        redirect_pc = 32'h0000_0102;
        tick();
        redirect = 1'b0;
        nr = reqs.size();
        ni = ipcs.size();
`ifdef FETCH_MISALIGN_EN
        total_cnt++; if (misalign !== 1'b1) $display("FAIL mis_pulse got %0b want 1", misalign); else pass_cnt++;
        tick();
        total_cnt++; if (misalign !== 1'b0) $display("FAIL mis_pulse_end got %0b want 0", misalign); else pass_cnt++;
        repeat (5) tick();
        total_cnt++; if (reqs.size() != nr) $display("FAIL mis_halt_reqs got %0d want %0d", reqs.size(), nr); else pass_cnt++;
        total_cnt++; if (inst_valid !== 1'b0) $display("FAIL mis_halt_inst_valid got %0b want 0", inst_valid); else pass_cnt++;
        redirect = 1'b1;
        redirect_pc = 32'h0000_0200;
        tick();
        redirect = 1'b0;
        ni = ipcs.size();
        n = 0;
        while (reqs.size() <= nr && n < 20) begin tick(); n++; end
        total_cnt++; if (qget(reqs, nr) !== 32'h200) $display("FAIL mis_resume_req got %h want 00000200", qget(reqs, nr)); else pass_cnt++;
        n = 0;
        while (ipcs.size() <= ni && n < 20) begin tick(); n++; end
        total_cnt++; if (qget(ipcs, ni) !== 32'h200) $display("FAIL mis_resume_pc got %h want 00000200", qget(ipcs, ni)); else pass_cnt++;
`else
        total_cnt++; if (imem_addr !== 32'h100) $display("FAIL mis_pc got %h want 00000100", imem_addr); else pass_cnt++;
        n = 0;
        while (reqs.size() <= nr && n < 20) begin tick(); n++; end
        total_cnt++; if (qget(reqs, nr) !== 32'h100) $display("FAIL mis_req got %h want 00000100", qget(reqs, nr)); else pass_cnt++;
        n = 0;
        while (ipcs.size() <= ni && n < 20) begin tick(); n++; end
        total_cnt++; if (qget(ipcs, ni) !== 32'h100) $display("FAIL mis_inst_pc got %h want 00000100", qget(ipcs, ni)); else pass_cnt++;
        total_cnt++; if (qget(idat, ni) !== 32'hFFFF_FEFF) $display("FAIL mis_inst got %h want fffffeff", qget(idat, ni)); else pass_cnt++;
`endif
    endtask

    task automatic test_async_reset();
        do_reset(2, 1'b1);
        repeat (7) tick();
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        total_cnt++; if (imem_req_valid !== 1'b0) $display("FAIL arst_req_valid got %0b want 0", imem_req_valid); else pass_cnt++;
        total_cnt++; if (imem_addr !== 32'h0) $display("FAIL arst_addr got %h want 00000000", imem_addr); else pass_cnt++;
        total_cnt++; if (inst_valid !== 1'b0) $display("FAIL arst_inst_valid got %0b want 0", inst_valid); else pass_cnt++;
        total_cnt++; if (inst !== 32'h0) $display("FAIL arst_inst got %h want 00000000", inst); else pass_cnt++;
        total_cnt++; if (inst_pc !== 32'h0) $display("FAIL arst_inst_pc got %h want 00000000", inst_pc); else pass_cnt++;
        total_cnt++; if (hi_addr !== 32'hFFFF_FFF8) $display("FAIL arst_hi_addr got %h want fffffff8", hi_addr); else pass_cnt++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_no_overflow();
        total_cnt++; if (ovf !== 1'b0) $display("FAIL buffer_overflow got %0b want 0", ovf); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_flush();
        test_wrap();
        test_misalign();
        test_async_reset();
        test_no_overflow();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
